// File: rtl/nios_system_nios2_qsys_0_mul_seq.sv
// Multi-pass 32x32 multiply sequencer: four 16x16 partial products through a low-product cell, 64-bit accumulate, signed high-word fix.
// Latency: start accepted at cycle 0 -> done at cycle CELL_LATENCY+6 (CELL_LATENCY+2 for op=00 when MUL_SEQ_FAST_LO_EN is defined).
// Backpressure: none; start is only sampled while busy=0, requests arriving while busy are dropped.
module nios_system_nios2_qsys_0_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIX} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc;
  logic        tag_vld [CELL_LATENCY];
  logic [1:0]  tag_k   [CELL_LATENCY];

  logic        accept;
  logic        fast_q;
  logic        fast_in;
  logic        last_issue;
  logic        last_drain;
  logic [1:0]  nxt_k;
  logic [5:0]  acc_sh;
  logic [31:0] hi;
  logic [31:0] fixed;

`ifdef MUL_SEQ_FAST_LO_EN
  // Low-word multiply needs only one full-width pass through the cell.
  assign fast_in = (op == 2'b00);
  assign fast_q  = (op_q == 2'b00);
`else
  assign fast_in = 1'b0;
  assign fast_q  = 1'b0;
`endif

  assign accept     = (state == IDLE) && start;
  assign busy       = (state != IDLE);
  assign last_issue = (cnt == 2'd3) || fast_q;
  assign last_drain = (cnt == 2'(CELL_LATENCY - 1));
  assign nxt_k      = cnt + 2'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> ISSUE (4 passes) -> DRAIN (cell latency) -> FIX -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (last_issue) state_nxt = DRAIN;
      DRAIN: if (last_drain) state_nxt = fast_q ? IDLE : FIX;
      FIX:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulate shift for the pass leaving the tag pipe, and the signed high-word correction.
  always_comb begin
    acc_sh = 6'd16;
    if (tag_k[CELL_LATENCY-1] == 2'd0) acc_sh = 6'd0;
    else if (tag_k[CELL_LATENCY-1] == 2'd3) acc_sh = 6'd32;
    hi    = acc[63:32];
    fixed = hi;
    case (op_q)
      2'b00: fixed = acc[31:0];
      2'b01: fixed = hi;
      2'b10: fixed = hi - (a_q[31] ? b_q : 32'd0);
      2'b11: fixed = hi - (a_q[31] ? b_q : 32'd0) - (b_q[31] ? a_q : 32'd0);
      default: fixed = hi;
    endcase
  end

  // Operand latch, pass issue, in-flight tag pipe, accumulator and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 2'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc      <= 64'd0;
      mul_src1 <= 32'd0;
      mul_src2 <= 32'd0;
      result   <= 32'd0;
      done     <= 1'b0;
      for (int i = 0; i < CELL_LATENCY; i++) begin
        tag_vld[i] <= 1'b0;
        tag_k[i]   <= 2'd0;
      end
    end else begin
      cnt  <= (state_nxt != state) ? 2'd0 : cnt + 2'd1;
      done <= 1'b0;

      // Pass k selects the high half of src1 on k[0] and of src2 on k[1].
      if (accept) begin
        op_q     <= op;
        a_q      <= src1;
        b_q      <= src2;
        mul_src1 <= fast_in ? src1 : {16'd0, src1[15:0]};
        mul_src2 <= fast_in ? src2 : {16'd0, src2[15:0]};
      end else if (state == ISSUE && !last_issue) begin
        mul_src1 <= {16'd0, nxt_k[0] ? a_q[31:16] : a_q[15:0]};
        mul_src2 <= {16'd0, nxt_k[1] ? b_q[31:16] : b_q[15:0]};
      end else begin
        mul_src1 <= 32'd0;
        mul_src2 <= 32'd0;
      end

      for (int i = CELL_LATENCY - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_k[i]   <= tag_k[i-1];
      end
      tag_vld[0] <= (state == ISSUE);
      tag_k[0]   <= cnt;

      if (accept) acc <= 64'd0;
      else if (tag_vld[CELL_LATENCY-1]) acc <= acc + (64'(mul_cell_result) << acc_sh);

      if (state == DRAIN && last_drain && fast_q) begin
        result <= mul_cell_result;
        done   <= 1'b1;
      end else if (state == FIX) begin
        result <= fixed;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_mul_seq.sv
// Self-checking bench: directed vector table and corner sequences on a CELL_LATENCY=1 instance,
// randomized ops against a 64-bit reference product on a CELL_LATENCY=3 instance.
module tb_nios_system_nios2_qsys_0_mul_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] src1, src2;

  logic        busy1, done1, busy3, done3;
  logic [31:0] result1, ms1a, ms1b, cr1;
  logic [31:0] result3, ms3a, ms3b, cr3;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  nios_system_nios2_qsys_0_mul_seq #(.CELL_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .busy(busy1), .done(done1), .result(result1),
    .mul_src1(ms1a), .mul_src2(ms1b), .mul_cell_result(cr1));

  nios_system_nios2_qsys_0_mul_seq #(.CELL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .busy(busy3), .done(done3), .result(result3),
    .mul_src1(ms3a), .mul_src2(ms3b), .mul_cell_result(cr3));

  // Low-product multiplier cells with 1 and 3 cycles of latency.
  logic [31:0] cp1 [1];
  logic [31:0] cp3 [3];
  always @(posedge clk) begin
    cp1[0] <= ms1a * ms1b;
    cp3[0] <= ms3a * ms3b;
    cp3[1] <= cp3[0];
    cp3[2] <= cp3[1];
  end
  assign cr1 = cp1[0];
  assign cr3 = cp3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int exp_lat(input logic [1:0] o, input int lat);
`ifdef MUL_SEQ_FAST_LO_EN
    if (o == 2'b00) return lat + 2;
`endif
    return lat + 6;
  endfunction

  // Reference: true 64-bit product of the operands interpreted per op.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b10 || o == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Counts cycles from cycle 1 until the selected instance pulses done (bounded).
  task automatic wait_done(input int sel, output int lat);
    lat = 1;
    while (!((sel == 1) ? done3 : done1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(sel, lat);
    res = (sel == 1) ? result3 : result1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] res;
  int          lat, n_done, first_done;

  initial begin
    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[4] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000000};
    vecs[7] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001};

    reset = 1'b1; start = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_result", result1, 32'd0);
    check("rst_mul_src1", ms1a, 32'd0);
    check("rst_mul_src2", ms1b, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op, 1));
      check($sformatf("vec%0d_busy_at_done", i), {31'd0, busy1}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done1}, 32'd0);
      check($sformatf("vec%0d_idle_src1", i), ms1a, 32'd0);
    end

    // Starts while busy must be ignored.
    start = 1'b1; op = 2'b01; src1 = 32'h2; src2 = 32'h3;
    @(posedge clk); #1;
    n_done = 0; first_done = 0; res = 32'hDEADBEEF;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (done1) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
        res = result1;
      end
      if (cyc == 2 || cyc == 5) begin
        start = 1'b1; op = 2'b01; src1 = 32'hFFFFFFFF; src2 = 32'h12345678;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("ignore_done_count", n_done, 32'd1);
    check("ignore_latency", first_done, 32'd7);
    check("ignore_result", res, 32'h00000000);

    // Back-to-back: new request presented in the done cycle.
    do_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    check("b2b_first_latency", lat, 32'd7);
    check("b2b_first_result", res, 32'hFFFFFFFE);
    check("b2b_busy_in_done", {31'd0, busy1}, 32'd0);
    start = 1'b1; op = 2'b00; src1 = 32'h0000FFFF; src2 = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_after", {31'd0, busy1}, 32'd1);
    wait_done(0, lat);
    check("b2b_second_latency", lat, exp_lat(2'b00, 1));
    check("b2b_second_result", result1, 32'hFFFE0001);

    // Reset in cycle 3 of a mulxss aborts cleanly.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; src1 = 32'h80000000; src2 = 32'h80000001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_result", result1, 32'd0);
    check("abort_mul_src1", ms1a, 32'd0);
    check("abort_mul_src2", ms1b, 32'd0);
    reset = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done1) n_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", n_done, 32'd0);
    do_op(0, 2'b00, 32'h0000FFFF, 32'h0000FFFF, res, lat);
    check("post_abort_result", res, 32'hFFFE0001);
    check("post_abort_latency", lat, exp_lat(2'b00, 1));

    // Randomized ops on the 3-cycle-latency instance.
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) ra = 32'h80000000;
      if (i % 16 == 1) rb = 32'hFFFFFFFF;
      do_op(1, ro, ra, rb, res, lat);
      check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, ro, ra, rb), res, ref_mul(ro, ra, rb));
      check($sformatf("rand%0d_latency", i), lat, exp_lat(ro, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
